vmem1_scan: RTL and testbench

- Debug/diagnostic reader for the second-stage virtual memory map (1024 x 24-bit map RAM).
- On request, walks a range of map addresses, drives the map's read port, and captures each registered 24-bit entry.
- Streams each entry, with its address, over a valid/ready interface to the debug/console path.
- Sits beside the processor's map access logic; yields the map port to any processor read or write in the same cycle.

---
 rtl/vmem1_scan.sv | 160 ++++++++++++++++
 tb/tb_vmem1_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem1_scan.sv
// vmem1_scan: walks a map address range, reads each entry and streams {adr,data,last} over valid/ready.
// First beat 2 cycles after start, 3 cycles/entry min; beat held while dout_ready=0. Optional csum: VMEM1_SCAN_CSUM_EN.
module vmem1_scan #(
  parameter int ADR_W  = 10,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADR_W-1:0]  first_adr,
  input  logic [ADR_W-1:0]  last_adr,
  input  logic              cpu_busy,
  output logic [4:0]        scan_vmap,
  output logic [4:0]        scan_mapi,
  output logic              scan_rp,
  input  logic [DATA_W-1:0] vmo,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADR_W-1:0]  dout_adr,
  output logic              dout_last,
  output logic              busy,
  output logic              done
`ifdef VMEM1_SCAN_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADR_W-1:0]    cur_adr_q, cur_adr_d;
  logic [ADR_W-1:0]    end_adr_q, end_adr_d;
  logic                dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0]   dout_data_q, dout_data_d;
  logic [ADR_W-1:0]    dout_adr_q, dout_adr_d;
  logic                dout_last_q, dout_last_d;
  logic                done_q, done_d;
  logic                scan_rp_d;
`ifdef VMEM1_SCAN_CSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d      = state_q;
    cur_adr_d    = cur_adr_q;
    end_adr_d    = end_adr_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_adr_d   = dout_adr_q;
    dout_last_d  = dout_last_q;
    done_d       = 1'b0;
    scan_rp_d    = 1'b0;
`ifdef VMEM1_SCAN_CSUM_EN
    csum_d       = csum_q;
`endif
    // abort overrides everything, including a pending start or handshake
    if (abort) begin
      state_d      = S_IDLE;
      dout_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_adr_d = first_adr;
            end_adr_d = last_adr;
            state_d   = S_READ;
`ifdef VMEM1_SCAN_CSUM_EN
            csum_d    = '0;
`endif
          end
        end
        S_READ: begin
          scan_rp_d = ~cpu_busy;
          if (!cpu_busy) state_d = S_CAPT;
        end
        S_CAPT: begin
          dout_data_d  = vmo;
          dout_adr_d   = cur_adr_q;
          dout_last_d  = (cur_adr_q == end_adr_q);
          dout_valid_d = 1'b1;
          state_d      = S_OUT;
`ifdef VMEM1_SCAN_CSUM_EN
          csum_d       = {csum_q[DATA_W-2:0], csum_q[DATA_W-1]} ^ vmo;
`endif
        end
        S_OUT: begin
          if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
            if (dout_last_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              cur_adr_d = cur_adr_q + ADR_W'(1);
              state_d   = S_READ;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_adr_q    <= '0;
      end_adr_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_adr_q   <= '0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef VMEM1_SCAN_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_adr_q    <= cur_adr_d;
      end_adr_q    <= end_adr_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_adr_q   <= dout_adr_d;
      dout_last_q  <= dout_last_d;
      done_q       <= done_d;
`ifdef VMEM1_SCAN_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign scan_vmap  = cur_adr_q[ADR_W-1 -: 5];
  assign scan_mapi  = cur_adr_q[4:0];
  assign scan_rp    = scan_rp_d;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_adr   = dout_adr_q;
  assign dout_last  = dout_last_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
`ifdef VMEM1_SCAN_CSUM_EN
  assign csum       = csum_q;
`endif

  a_rp_yields: assert property (@(posedge clk) disable iff (!reset_n)
    scan_rp |-> !cpu_busy);
  a_hold_stall: assert property (@(posedge clk) disable iff (!reset_n)
    (dout_valid && !dout_ready && !abort) |=>
      (dout_valid && $stable(dout_data) && $stable(dout_adr) && $stable(dout_last)));
  a_done_idle: assert property (@(posedge clk) disable iff (!reset_n)
    done |-> !busy);

endmodule

// File: tb/tb_vmem1_scan.sv
// Scoreboard bench for vmem1_scan: map RAM model, random scans, directed stall/abort/reset cases.
module tb_vmem1_scan;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  first_adr = '0;
  logic [9:0]  last_adr = '0;
  logic        dir_cpu = 1'b0;
  logic        dir_ready = 1'b1;
  logic        rnd_en = 1'b0;
  logic        rnd_cpu = 1'b0;
  logic        rnd_ready = 1'b1;
  logic [9:0]  cpu_adr = '0;
  logic        cpu_busy;
  logic        dout_ready;
  logic [4:0]  scan_vmap, scan_mapi;
  logic        scan_rp;
  logic [23:0] vmo = '0;
  logic        dout_valid, dout_last, busy, done;
  logic [23:0] dout_data;
  logic [9:0]  dout_adr;
`ifdef VMEM1_SCAN_CSUM_EN
  logic [23:0] csum;
`endif

  typedef struct packed {
    logic [9:0]  adr;
    logic [23:0] dat;
    logic        last;
  } beat_t;

  logic [23:0] map [1024];
  beat_t       exp_q[$];
  logic [23:0] exp_csum = '0;
  int          exp_n = 0;
  int          rp_cnt = 0, done_cnt = 0, rp_base = 0, done_base = 0;
  int          n_pass = 0, n_chk = 0;
  int          ready_pct = 100, cpu_pct = 0;

  assign cpu_busy   = rnd_en ? rnd_cpu : dir_cpu;
  assign dout_ready = rnd_en ? rnd_ready : dir_ready;

  vmem1_scan dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .first_adr(first_adr), .last_adr(last_adr), .cpu_busy(cpu_busy),
    .scan_vmap(scan_vmap), .scan_mapi(scan_mapi), .scan_rp(scan_rp), .vmo(vmo),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_adr(dout_adr), .dout_last(dout_last), .busy(busy), .done(done)
`ifdef VMEM1_SCAN_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  // Map RAM: registered output, the processor owns the port whenever cpu_busy
  always @(posedge clk) begin
    if (cpu_busy) vmo <= map[cpu_adr];
    else if (scan_rp) vmo <= map[{scan_vmap, scan_mapi}];
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(99) < ready_pct);
    rnd_cpu   = ($urandom_range(99) < cpu_pct);
    cpu_adr   = 10'($urandom);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every accepted beat
  always @(negedge clk) begin
    if (reset_n) begin
      if (scan_rp) begin
        rp_cnt++;
        chk("rp_while_cpu", {63'd0, cpu_busy}, 64'd0);
      end
      if (dout_valid && dout_ready && !abort) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL beat_unexpected: actual adr=%0d data=%0h required none", dout_adr, dout_data);
        end else begin
          chk("beat", {29'd0, dout_adr, dout_data, dout_last}, {29'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("q_empty_at_done", 64'(exp_q.size()), 64'd0);
`ifdef VMEM1_SCAN_CSUM_EN
        chk("csum_at_done", {40'd0, csum}, {40'd0, exp_csum});
`endif
      end
    end
  end

  task automatic do_start(input logic [9:0] f, input logic [9:0] l);
    logic [9:0] a;
    exp_n = ((int'(l) - int'(f) + 1024) % 1024) + 1;
    exp_csum = '0;
    for (int k = 0; k < exp_n; k++) begin
      a = 10'((int'(f) + k) % 1024);
      exp_q.push_back(beat_t'({a, map[a], (k == exp_n - 1)}));
      exp_csum = {exp_csum[22:0], exp_csum[23]} ^ map[a];
    end
    rp_base = rp_cnt;
    done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; first_adr = f; last_adr = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_scan(input string name, input int budget);
    int c = 0;
    while (done_cnt == done_base && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (done_cnt == done_base) begin
      n_chk++;
      $display("FAIL %s_timeout: actual no done after %0d cycles required done", name, budget);
    end
    repeat (2) @(negedge clk);
    chk({name, "_done_cnt"}, 64'(done_cnt - done_base), 64'd1);
    chk({name, "_rp_cnt"}, 64'(rp_cnt - rp_base), 64'(exp_n));
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!dout_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!dout_valid) begin
      n_chk++;
      $display("FAIL wait_valid: actual dout_valid=0 after %0d cycles required 1", budget);
    end
  endtask

  initial begin
    logic [23:0] d0;
    logic [9:0]  a0;
    logic [9:0]  f, l;
    int          rp0, len;
    for (int i = 0; i < 1024; i++) map[i] = 24'($urandom);
    #2;
    chk("rst_ctrl", {60'd0, busy, done, scan_rp, dout_valid}, 64'd0);
    chk("rst_dout", {29'd0, dout_last, dout_data, dout_adr}, 64'd0);
    chk("rst_scan_adr", {54'd0, scan_vmap, scan_mapi}, 64'd0);
`ifdef VMEM1_SCAN_CSUM_EN
    chk("rst_csum", {40'd0, csum}, 64'd0);
`endif
    #10 reset_n = 1'b1;

    map[5] = 24'h123456;
    map[6] = 24'hABCDEF;
    do_start(10'd5, 10'd6);
    finish_scan("pair", 40);

    do_start(10'd1022, 10'd1);
    finish_scan("wrap", 60);

    do_start(10'd100, 10'd102);
    dir_cpu = 1'b1;
    repeat (4) @(posedge clk);
    #1 dir_cpu = 1'b0;
    finish_scan("cpu_stall", 60);

    dir_ready = 1'b0;
    do_start(10'd200, 10'd201);
    wait_valid(20);
    d0 = dout_data; a0 = dout_adr; rp0 = rp_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("stall_hold", {30'd0, dout_valid, dout_adr, dout_data}, {30'd0, 1'b1, a0, d0});
    end
    chk("stall_no_rp", 64'(rp_cnt - rp0), 64'd0);
    @(posedge clk); #1 dir_ready = 1'b1;
    finish_scan("ready_stall", 40);

    dir_ready = 1'b0;
    do_start(10'd300, 10'd310);
    wait_valid(20);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_out_state", {62'd0, dout_valid, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - done_base), 64'd0);
    exp_q.delete();
    dir_ready = 1'b1;
    do_start(10'd300, 10'd303);
    finish_scan("rescan", 60);

    do_start(10'd600, 10'd605);
    abort = 1'b1;
    #1 chk("abort_read_rp", {63'd0, scan_rp}, 64'd0);
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_read_busy", {63'd0, busy}, 64'd0);
    exp_q.delete();

    do_start(10'd400, 10'd403);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; first_adr = 10'd0; last_adr = 10'd1;
    @(posedge clk); #1 start = 1'b0;
    finish_scan("start_busy", 60);

    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("start_abort_valid", {63'd0, dout_valid}, 64'd0);

    rnd_en = 1'b1;
    for (int it = 0; it < 15; it++) begin
      ready_pct = $urandom_range(40, 100);
      cpu_pct = $urandom_range(0, 50);
      f = 10'($urandom);
      len = $urandom_range(1, 12);
      l = f + 10'(len - 1);
      do_start(f, l);
      finish_scan("random", len * 40 + 40);
    end
    ready_pct = 100;
    cpu_pct = 0;
    @(posedge clk); #2 rnd_en = 1'b0;

    do_start(10'd0, 10'd1023);
    finish_scan("full_map", 3200);

`ifdef VMEM1_SCAN_CSUM_EN
    map[0] = 24'h1; map[1] = 24'h2; map[2] = 24'h4;
    do_start(10'd0, 10'd2);
    finish_scan("csum", 40);
    chk("csum_fixed", {40'd0, csum}, 64'h4);
`endif

    do_start(10'd500, 10'd520);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("async_reset", {25'd0, busy, done, scan_rp, dout_valid, dout_last, dout_data, dout_adr, scan_vmap, scan_mapi}, 64'd0);
    exp_q.delete();
    @(negedge clk) reset_n = 1'b1;
    do_start(10'd700, 10'd703);
    finish_scan("after_reset", 60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
